// File: rtl/amber48_pkg.sv
// rtl/amber48_pkg.sv - shared amber48 types for the execute/memory/writeback boundary
package amber48_pkg;

    localparam int XLEN   = 48;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        TRAP_NONE       = 4'd0,
        TRAP_ILLEGAL    = 4'd1,
        TRAP_MISALIGNED = 4'd2,
        TRAP_ECALL      = 4'd3,
        TRAP_BUS_FAULT  = 4'd4
    } amber48_trap_e;

    typedef struct packed {
        logic                valid;
        logic [REG_AW-1:0]   rd;
        logic [XLEN-1:0]     result;
        logic [XLEN-1:0]     store_data;
        logic                writeback_en;
        logic                load;
        logic                store;
        logic                branch_taken;
        logic [XLEN-1:0]     branch_target;
        logic                trap;
        amber48_trap_e       trap_cause;
    } amber48_execute_out_s;

    typedef struct packed {
        logic                valid;
        logic [REG_AW-1:0]   rd;
        logic [XLEN-1:0]     data;
        logic                writeback_en;
        logic                trap;
        amber48_trap_e       trap_cause;
    } amber48_mem_wb_s;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_REQ,
        MEM_WAIT_R
    } mem_state_e;

    // Builds a valid writeback record; every pulse of wb_o goes through here.
    function automatic amber48_mem_wb_s mk_wb(
        input logic [REG_AW-1:0] rd,
        input logic [XLEN-1:0]   data,
        input logic              wb_en,
        input logic              trap,
        input amber48_trap_e     cause
    );
        amber48_mem_wb_s w;
        w.valid        = 1'b1;
        w.rd           = rd;
        w.data         = data;
        w.writeback_en = wb_en;
        w.trap         = trap;
        w.trap_cause   = cause;
        return w;
    endfunction

endpackage

// File: rtl/amber48_timeout_ctr.sv
// rtl/amber48_timeout_ctr.sv - bus wait watchdog for the memory stage
module amber48_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Expiry fires on the cycle that would bring the count to TIMEOUT_CYCLES,
    // so the request is held for exactly TIMEOUT_CYCLES cycles before dropping.
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count idle waiting cycles.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES > 0) && enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/amber48_mem_stage.sv
// rtl/amber48_mem_stage.sv - amber48 memory-access stage with request/grant/response bus
module amber48_mem_stage
    import amber48_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  amber48_execute_out_s ex_i,
    output logic                 ex_ready_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [XLEN-1:0]      dmem_addr_o,
    output logic [XLEN-1:0]      dmem_wdata_o,
    input  logic                 dmem_gnt_i,
    input  logic                 dmem_rvalid_i,
    input  logic [XLEN-1:0]      dmem_rdata_i,
    output amber48_mem_wb_s      wb_o,
    output logic                 redirect_valid_o,
    output logic [XLEN-1:0]      redirect_pc_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    mem_state_e        state_q;
    logic [REG_AW-1:0] rd_q;
    logic              wb_en_q;
    logic              to_clear;
    logic              to_enable;
    logic              to_expired;

    assign ex_ready_o = (state_q == MEM_IDLE);

    // The watchdog sits at zero in IDLE, restarts when the grant moves us to
    // WAIT_R, and only advances while the awaited event is absent.
    assign to_clear  = (state_q == MEM_IDLE) || ((state_q == MEM_REQ) && dmem_gnt_i);
    assign to_enable = ((state_q == MEM_REQ) && !dmem_gnt_i) ||
                       ((state_q == MEM_WAIT_R) && !dmem_rvalid_i);

    amber48_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (to_clear),
        .enable_i  (to_enable),
        .expired_o (to_expired)
    );

    // Stage FSM: accepts execute records, runs the bus transaction and emits
    // single-cycle writeback/redirect pulses from registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= MEM_IDLE;
            dmem_req_o       <= 1'b0;
            dmem_we_o        <= 1'b0;
            dmem_addr_o      <= '0;
            dmem_wdata_o     <= '0;
            rd_q             <= '0;
            wb_en_q          <= 1'b0;
            wb_o             <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            wb_o             <= '0;
            redirect_valid_o <= 1'b0;
            case (state_q)
                MEM_IDLE: begin
                    if (ex_i.valid) begin
                        if (ex_i.trap || (ex_i.load && ex_i.store)) begin
                            wb_o <= mk_wb(ex_i.rd, ex_i.result, 1'b0, 1'b1,
                                          ex_i.trap ? ex_i.trap_cause : TRAP_ILLEGAL);
                        end else if (ex_i.load || ex_i.store) begin
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= ex_i.store;
                            dmem_addr_o  <= ex_i.result;
                            dmem_wdata_o <= ex_i.store_data;
                            rd_q         <= ex_i.rd;
                            wb_en_q      <= ex_i.writeback_en;
                            state_q      <= MEM_REQ;
                        end else begin
                            wb_o <= mk_wb(ex_i.rd, ex_i.result, ex_i.writeback_en, 1'b0, TRAP_NONE);
                            if (ex_i.branch_taken) begin
                                redirect_valid_o <= 1'b1;
                                redirect_pc_o    <= ex_i.branch_target;
                            end
                        end
                    end
                end
                MEM_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (dmem_we_o) begin
                            wb_o    <= mk_wb(rd_q, {XLEN{1'b0}}, 1'b0, 1'b0, TRAP_NONE);
                            state_q <= MEM_IDLE;
                        end else if (dmem_rvalid_i) begin
                            wb_o    <= mk_wb(rd_q, dmem_rdata_i, wb_en_q, 1'b0, TRAP_NONE);
                            state_q <= MEM_IDLE;
                        end else begin
                            state_q <= MEM_WAIT_R;
                        end
                    end else if (to_expired) begin
                        dmem_req_o <= 1'b0;
                        wb_o       <= mk_wb(rd_q, {XLEN{1'b0}}, 1'b0, 1'b1, TRAP_BUS_FAULT);
                        state_q    <= MEM_IDLE;
                    end
                end
                MEM_WAIT_R: begin
                    if (dmem_rvalid_i) begin
                        wb_o    <= mk_wb(rd_q, dmem_rdata_i, wb_en_q, 1'b0, TRAP_NONE);
                        state_q <= MEM_IDLE;
                    end else if (to_expired) begin
                        wb_o    <= mk_wb(rd_q, {XLEN{1'b0}}, 1'b0, 1'b1, TRAP_BUS_FAULT);
                        state_q <= MEM_IDLE;
                    end
                end
                default: begin
                    state_q <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule
